time_keeper: RTL
================

# time_keeper

Time-of-day counter that consumes the divided 1 kHz square wave produced by the clock-divider stage and maintains an HH:MM:SS BCD time plus a binary millisecond count for the VGA display path. It runs entirely in the clkin domain: the divider output is treated as an asynchronous level, synchronised, and edge-detected into a one-cycle tick enable. A valid/ready port lets the control logic load a new time, and each load is checked for BCD legality.

## Interface
Parameters:
- MS_PER_SEC, 1000: ticks per second; ms wraps at MS_PER_SEC-1.
- HOUR_MAX, 23: last hour value before the hours field wraps to 00; must be 1..23.

Ports:
- clkin  in  1  system clock, 50 MHz.
- rst_N  in  1  reset, asynchronous, active-low.
- tick_in  in  1  divided clock from the divider stage (about 1 kHz square wave), asynchronous to clkin.
- run  in  1  level; when 1, the block counts ticks.
- clear  in  1  synchronous one-cycle request to zero the time.
- set_valid  in  1  a load request is pending.
- set_ready  out  1  the block can accept a load this cycle.
- set_time  in  24  BCD {H1,H0,M1,M0,S1,S0}, 4 bits per digit.
- set_err  out  1  one-cycle pulse: the accepted load was illegal and has been discarded.
- time_bcd  out  24  current time, same packing as set_time.
- ms  out  10  binary millisecond count, 0..MS_PER_SEC-1.
- sec_pulse  out  1  one-cycle pulse on every ms wrap.
- running  out  1  1 while in ST_RUN.

## Operation
- Tick path: tick_in passes through 2 flops (s1, s2) then a history flop (s3). rise = s2 & ~s3. Only rising edges count.
- State machine:
  - ST_STOP: run=0; ticks are ignored; go to ST_RUN when run=1.
  - ST_RUN: each rise increments ms; go to ST_STOP when run=0.
  - ST_LOAD: lasts exactly 1 cycle after an accepted load, then goes to ST_RUN if run=1, otherwise to ST_STOP.
- Load handshake: set_ready = 1 in ST_STOP and ST_RUN, 0 in ST_LOAD and in reset. A load is accepted when set_valid & set_ready; set_time is captured on that edge.
- Load check in ST_LOAD:
  - Legal means every digit is 0..9, S1 ≤ 5, M1 ≤ 5, and hours ≤ HOUR_MAX.
  - Legal: time_bcd ← captured value and ms ← 0.
  - Illegal: set_err pulses for 1 cycle and the time is unchanged.
- Counting carries: ms MS_PER_SEC-1 → 0 increments the seconds field and pulses sec_pulse. Seconds 59→00 carries into minutes; minutes 59→00 carries into hours; hours HOUR_MAX→00. The BCD carry is per digit (S0 9→0 increments S1, and so on).
- A rise that falls in ST_LOAD is dropped, not deferred.
- Priority within one cycle: clear > load acceptance > tick.
- clear sets time_bcd=0 and ms=0, aborts a pending ST_LOAD (no set_err), and the next state follows run. A clear in the same cycle as a load request also blocks acceptance: set_ready stays high but the load is ignored.
- Reset values: time_bcd=0, ms=0, sec_pulse=0, set_err=0, set_ready=0, running=0, state=ST_STOP, s1/s2/s3=0. set_ready rises on the first clkin edge after rst_N deasserts.

## Timing
- Tick latency: if tick_in rises before clkin edge E1, ms updates on edge E3.
- sec_pulse and the seconds update occur on the same edge as the ms wrap.
- Load latency: set_valid sampled at edge A; time_bcd or set_err updates at edge A+1; set_ready is 0 during the cycle A→A+1.
- With divider constant N, ticks arrive every 2(N+1) clkin cycles. The block requires at least 4 cycles between rises.

## Configuration
- TIME_KEEPER_ALARM_EN defined:
  - Adds input alarm_time (24 bits, BCD) and output alarm (1 bit).
  - alarm pulses for 1 cycle when a counting carry makes time_bcd equal to alarm_time.
  - Loads and clear never raise alarm.
  - alarm resets to 0.
- Macro undefined: the alarm_time and alarm ports and their logic are absent; all other behaviour is identical.

## Structure
- Shared package holds: the state encoding (ST_STOP, ST_RUN, ST_LOAD), the BCD digit width (4), the time field width (24), and the digit-position constants.
- Sub-module bcd_digit has inputs inc and max, and outputs q and carry. It is instantiated once per time digit; ms stays a plain binary counter.

## Test plan
- Reset, then run=1, then 1000 rises of tick_in → time_bcd=24'h000001, ms=0, exactly one sec_pulse.
- Load 24'h235959 with run=1, then 1000 rises → time_bcd=24'h000000, set_err stays 0.
- Load 24'h126000 → set_err pulses 1 cycle, time unchanged. Load 24'h2A0000 → set_err pulses. Load 24'h240000 with HOUR_MAX=23 → set_err pulses.
- clear and set_valid in the same cycle with time 24'h101010 → time_bcd=0, load ignored, no set_err.
- run=0 then 50 rises → ms and time_bcd frozen, running=0. Then run=1 and 1 rise → ms=1, 3 edges after the tick_in rise.
- With TIME_KEEPER_ALARM_EN, alarm_time=24'h000002: loading 24'h000002 gives no alarm. Clear, then 2000 rises → alarm pulses once, on the edge where time becomes 000002.

Source files
------------

// File: rtl/time_keeper_pkg.sv
// time_keeper_pkg
//   Shared definitions for the time_keeper block: FSM state encoding, BCD
//   digit/field widths, digit positions inside the packed HH:MM:SS word,
//   and the load-legality check used when a new time is presented.
//   Packing of a time word: {H1,H0,M1,M0,S1,S0}, 4 bits per digit, S0 in [3:0].
package time_keeper_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int TIME_W     = 24;
    localparam int NUM_DIGITS = TIME_W / DIGIT_W;

    localparam int POS_S0 = 0;
    localparam int POS_S1 = 1;
    localparam int POS_M0 = 2;
    localparam int POS_M1 = 3;
    localparam int POS_H0 = 4;
    localparam int POS_H1 = 5;

    // A time word is legal when every digit is decimal, the tens of seconds
    // and minutes stay below 6, and the hours value does not exceed hour_max.
    function automatic logic bcd_time_legal(input logic [TIME_W-1:0] t,
                                            input int hour_max);
        logic ok;
        int   hours;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (t[i*DIGIT_W +: DIGIT_W] > 4'd9) ok = 1'b0;
        if (t[POS_S1*DIGIT_W +: DIGIT_W] > 4'd5) ok = 1'b0;
        if (t[POS_M1*DIGIT_W +: DIGIT_W] > 4'd5) ok = 1'b0;
        hours = 10 * int'(t[POS_H1*DIGIT_W +: DIGIT_W])
              + int'(t[POS_H0*DIGIT_W +: DIGIT_W]);
        if (hours > hour_max) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/time_keeper_bcd_digit.sv
// bcd_digit
//   One BCD digit of the time-of-day counter. Counts 0..max on inc and
//   wraps to 0, flagging carry in the same cycle so the next digit up
//   advances on the same edge.
//   Ports:
//     clkin, rst_N  clock / async active-low reset
//     clr           synchronous zero (highest priority)
//     load          synchronous load of load_val
//     load_val      digit value to load
//     inc           advance this digit
//     max           last value before wrapping (may change at run time)
//     q             current digit value
//     carry         inc while at max: the next digit advances
module bcd_digit
    import time_keeper_pkg::*;
(
    input  logic               clkin,
    input  logic               rst_N,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               inc,
    input  logic [DIGIT_W-1:0] max,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    assign carry = inc & (q == max);

    always_ff @(posedge clkin or negedge rst_N) begin
        if (!rst_N)     q <= '0;
        else if (clr)   q <= '0;
        else if (load)  q <= load_val;
        else if (inc)   q <= (q == max) ? '0 : q + DIGIT_W'(1);
    end

endmodule

// File: rtl/time_keeper.sv
// time_keeper
//   Time-of-day counter driven by the ~1 kHz divider output. tick_in is
//   synchronised into clkin, rising edges become one-cycle count enables,
//   and a binary ms counter feeds a chain of BCD digits (HH:MM:SS).
//   A valid/ready port loads a new time after a one-cycle legality check.
//   Optional feature macro: TIME_KEEPER_ALARM_EN (adds alarm_time / alarm).
//   Ports:
//     clkin, rst_N        clock / async active-low reset
//     tick_in             divider output, asynchronous level
//     run                 count enable level
//     clear               one-cycle request to zero the time
//     set_valid/set_ready load handshake, set_time is the BCD value
//     set_err             pulse: accepted load was illegal and discarded
//     time_bcd, ms        current time and millisecond count
//     sec_pulse           pulse on every ms wrap
//     running             1 while counting (ST_RUN)
//     alarm_time, alarm   (alarm build only) pulse when counting hits alarm_time
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter int MS_PER_SEC = 1000,
    parameter int HOUR_MAX   = 23
) (
    input  logic              clkin,
    input  logic              rst_N,
    input  logic              tick_in,
    input  logic              run,
    input  logic              clear,
    input  logic              set_valid,
    output logic              set_ready,
    input  logic [TIME_W-1:0] set_time,
`ifdef TIME_KEEPER_ALARM_EN
    input  logic [TIME_W-1:0] alarm_time,
    output logic              alarm,
`endif
    output logic              set_err,
    output logic [TIME_W-1:0] time_bcd,
    output logic [9:0]        ms,
    output logic              sec_pulse,
    output logic              running
);

    localparam int                 MS_W       = 10;
    localparam logic [MS_W-1:0]    MS_LAST    = MS_W'(MS_PER_SEC - 1);
    localparam logic [DIGIT_W-1:0] H1_MAX     = DIGIT_W'(HOUR_MAX / 10);
    localparam logic [DIGIT_W-1:0] H0_MAX_TOP = DIGIT_W'(HOUR_MAX % 10);

    // Two-flop synchroniser plus history flop for edge detection.
    logic s1, s2, s3, rise;

    always_ff @(posedge clkin or negedge rst_N) begin
        if (!rst_N) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tick_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    state_t            state;
    logic [TIME_W-1:0] cap;
    logic              accept, cap_legal, load_ok, ms_inc, sec_inc;

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] dq, dmax;
    logic [NUM_DIGITS-1:0]              dinc, dcarry;

    // clear blocks acceptance even though set_ready stays high.
    assign accept    = set_valid & set_ready & ~clear;
    assign cap_legal = bcd_time_legal(cap, HOUR_MAX);
    assign load_ok   = (state == ST_LOAD) & ~clear & cap_legal;
    // A rise outside ST_RUN (including during ST_LOAD) is simply dropped.
    assign ms_inc    = (state == ST_RUN) & rise & ~clear & ~accept;
    assign sec_inc   = ms_inc & (ms == MS_LAST);

    always_ff @(posedge clkin or negedge rst_N) begin
        if (!rst_N) begin
            state     <= ST_STOP;
            set_ready <= 1'b0;
            running   <= 1'b0;
            set_err   <= 1'b0;
            sec_pulse <= 1'b0;
            cap       <= '0;
        end else begin
            sec_pulse <= sec_inc;
            set_err   <= (state == ST_LOAD) & ~clear & ~cap_legal;
            if (accept) begin
                cap       <= set_time;
                state     <= ST_LOAD;
                set_ready <= 1'b0;
                running   <= 1'b0;
            end else begin
                // STOP, RUN, end of LOAD and clear all follow the run level.
                state     <= run ? ST_RUN : ST_STOP;
                set_ready <= 1'b1;
                running   <= run;
            end
        end
    end

    always_ff @(posedge clkin or negedge rst_N) begin
        if (!rst_N)                ms <= '0;
        else if (clear || load_ok) ms <= '0;
        else if (ms_inc)           ms <= (ms == MS_LAST) ? '0 : ms + MS_W'(1);
    end

    // Hours units wrap early only when the tens digit is at its top value,
    // so HOUR_MAX -> 00 falls out of the ordinary per-digit carry chain.
    assign dmax[POS_S0] = 4'd9;
    assign dmax[POS_S1] = 4'd5;
    assign dmax[POS_M0] = 4'd9;
    assign dmax[POS_M1] = 4'd5;
    assign dmax[POS_H0] = (dq[POS_H1] == H1_MAX) ? H0_MAX_TOP : 4'd9;
    assign dmax[POS_H1] = H1_MAX;

    assign dinc[0] = sec_inc;

    for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_chain
        assign dinc[i] = dcarry[i-1];
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clkin    (clkin),
            .rst_N    (rst_N),
            .clr      (clear),
            .load     (load_ok),
            .load_val (cap[i*DIGIT_W +: DIGIT_W]),
            .inc      (dinc[i]),
            .max      (dmax[i]),
            .q        (dq[i]),
            .carry    (dcarry[i])
        );
    end

    // Carry out of the hours tens digit marks midnight; nothing consumes it.
    logic midnight_unused;
    assign midnight_unused = dcarry[NUM_DIGITS-1];

    assign time_bcd = dq;

`ifdef TIME_KEEPER_ALARM_EN
    // sec_pulse is high exactly in the cycle after a counting update, so the
    // match is only qualified by counting carries, never by loads or clear.
    assign alarm = sec_pulse & (time_bcd == alarm_time);
`endif

endmodule
